// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer around a shared round datapath.
// Optional macro AES_BACK2BACK_EN lets a new block load during the DONE handshake.
module aes_round_ctrl #(
   parameter int NR  = 10,
   parameter int KIW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [0:127]   in_data,
   output logic [KIW-1:0] rk_idx,
   input  logic [0:127]   rk,
   input  logic           rk_valid,
   output logic [0:127]   dp_state,
   output logic           dp_last,
   input  logic [0:127]   dp_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [0:127]   out_data,
   output logic           busy
);

   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_ctrl: NR must be 10, 12 or 14");
   end

   if (NR >= (1 << KIW)) begin : g_bad_kiw
      $error("aes_round_ctrl: KIW too narrow for NR");
   end

`ifdef AES_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   localparam logic [KIW-1:0] ONE   = KIW'(1);
   localparam logic [KIW-1:0] NR_M1 = KIW'(NR - 1);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      FINAL,
      DONE
   } fsm_e;

   fsm_e           cs;
   fsm_e           ns;
   logic [0:127]   st_q;
   logic [0:127]   st_d;
   logic [KIW-1:0] rnd_q;
   logic [KIW-1:0] rnd_d;
   logic [KIW-1:0] idx_q;
   logic [KIW-1:0] idx_d;
   logic           last_rnd;
   logic           restart;

   assign last_rnd = (rnd_q == NR_M1);
   assign restart  = B2B && out_ready && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs <= IDLE;
      end else begin
         cs <= ns;
      end
   end

   always_comb begin
      ns = cs;
      unique case (cs)
         IDLE:  if (in_valid) ns = INIT;
         INIT:  if (rk_valid) ns = ROUND;
         ROUND: if (rk_valid && last_rnd) ns = FINAL;
         FINAL: if (rk_valid) ns = DONE;
         DONE: begin
            if (out_ready) ns = restart ? INIT : IDLE;
         end
         default: ns = IDLE;
      endcase
   end

   // State, round and key index advance only when a key is consumed
   always_comb begin
      st_d  = st_q;
      rnd_d = rnd_q;
      idx_d = idx_q;
      unique case (cs)
         IDLE: begin
            if (in_valid) begin
               st_d  = in_data;
               rnd_d = '0;
               idx_d = '0;
            end
         end
         INIT: begin
            if (rk_valid) begin
               st_d  = st_q ^ rk;
               rnd_d = ONE;
               idx_d = ONE;
            end
         end
         ROUND: begin
            if (rk_valid) begin
               st_d  = dp_result ^ rk;
               rnd_d = rnd_q + ONE;
               idx_d = rnd_q + ONE;
            end
         end
         FINAL: begin
            if (rk_valid) st_d = dp_result ^ rk;
         end
         DONE: begin
            if (out_ready) begin
               rnd_d = '0;
               idx_d = '0;
               if (restart) st_d = in_data;
            end
         end
         default: begin
            st_d = st_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= '0;
         rnd_q <= '0;
         idx_q <= '0;
      end else begin
         st_q  <= st_d;
         rnd_q <= rnd_d;
         idx_q <= idx_d;
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      dp_last   = 1'b0;
      busy      = 1'b1;
      unique case (cs)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         FINAL: begin
            dp_last = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = B2B && out_ready;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign rk_idx   = idx_q;
   assign dp_state = st_q;
   assign out_data = st_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized scoreboard bench for aes_round_ctrl.
// The bench supplies the key store and an AES round datapath model.
module tb_aes_round_ctrl;

   localparam int NR  = 10;
   localparam int KIW = 4;

`ifdef AES_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   typedef logic [0:127] blk_t;
   typedef logic [15:0][127:0] keys_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   blk_t           in_data = '0;
   logic [KIW-1:0] rk_idx;
   blk_t           rk;
   logic           rk_valid = 1'b1;
   blk_t           dp_state;
   logic           dp_last;
   blk_t           dp_result;
   logic           out_valid;
   logic           out_ready = 1'b1;
   blk_t           out_data;
   logic           busy;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   blk_t exp_q[$];

   keys_t cur_keys = '0;
   keys_t pend_keys = '0;
   bit    cur_id = 1'b1;
   bit    pend_id = 1'b1;
   bit    take = 1'b0;
   int    rkv_mode = 0;
   int    ordy_mode = 0;
   int    acc_cyc = 0;

   aes_round_ctrl #(.NR(NR), .KIW(KIW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .rk_valid  (rk_valid),
      .dp_state  (dp_state),
      .dp_last   (dp_last),
      .dp_result (dp_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic chki(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254, then the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
             {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic blk_t aes_rnd(input blk_t s, input logic last);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [7:0] x0, x1, x2, x3;
      logic [7:0] y0, y1, y2, y3;
      blk_t o;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[8*i +: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c + r] = a[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
         x0 = b[4*c];
         x1 = b[4*c + 1];
         x2 = b[4*c + 2];
         x3 = b[4*c + 3];
         if (last) begin
            y0 = x0; y1 = x1; y2 = x2; y3 = x3;
         end else begin
            y0 = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
            y1 = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
            y2 = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
            y3 = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
         end
         o[32*c +: 32] = {y0, y1, y2, y3};
      end
      return o;
   endfunction

   function automatic keys_t expand(input blk_t key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      keys_t       k;
      rc = 8'h01;
      k  = '0;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]),
                 sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++)
         k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return k;
   endfunction

   // Whole-block cipher: whitening key, then NR rounds, last without MixColumns
   function automatic blk_t aes_ref(input blk_t pt, input keys_t k,
                                    input bit id);
      blk_t s;
      s = pt ^ k[0];
      for (int r = 1; r <= NR; r++)
         s = (id ? s : aes_rnd(s, r == NR)) ^ k[r];
      return s;
   endfunction

   function automatic blk_t rnd_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic keys_t id_keys();
      keys_t k;
      for (int r = 0; r < 16; r++) k[r] = {16{8'(r)}};
      return k;
   endfunction

   function automatic keys_t rnd_keys();
      keys_t k;
      for (int r = 0; r < 16; r++) k[r] = rnd_blk();
      return k;
   endfunction

   // ---------------- key store and datapath ----------------
   always @(negedge clk) take <= in_valid && in_ready && rst_n;

   always @(posedge clk) begin
      if (take) begin
         cur_keys <= pend_keys;
         cur_id   <= pend_id;
      end
   end

   assign rk = cur_keys[rk_idx];

   always_comb dp_result = cur_id ? dp_state : aes_rnd(dp_state, dp_last);

   // ---------------- rk_valid / out_ready generator ----------------
   int stall_n = 0;

   always begin
      @(posedge clk);
      #1;
      if (rkv_mode == 2) begin
         if (busy && rk_idx == 4'd5 && stall_n < 3) begin
            rk_valid = 1'b0;
            stall_n++;
         end else begin
            rk_valid = 1'b1;
         end
      end else begin
         stall_n  = 0;
         rk_valid = (rkv_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (ordy_mode == 0) out_ready = 1'b1;
      else if (ordy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b0;
   end

   // ---------------- monitor: cycle model + scoreboard ----------------
   int m_left = 0;
   bit m_busy = 1'b0;
   bit m_ov = 1'b0;

   always @(negedge clk) begin
      bit exp_ir;
      bit nb;
      bit no;
      int nl;
      if (!rst_n) begin
         chkb("rst_in_ready", in_ready, 1'b1);
         chkb("rst_out_valid", out_valid, 1'b0);
         chkb("rst_busy", busy, 1'b0);
         chkb("rst_dp_last", dp_last, 1'b0);
         chki("rst_rk_idx", int'(rk_idx), 0);
         chk("rst_out_data", out_data, '0);
         m_busy = 1'b0;
         m_left = 0;
         m_ov   = 1'b0;
      end else begin
         exp_ir = !m_busy || (B2B && m_ov && out_ready);
         chkb("in_ready", in_ready, exp_ir);
         chkb("busy", busy, m_busy);
         chkb("out_valid", out_valid, m_ov);
         chkb("dp_last", dp_last, m_busy && m_left == 1);
         if (m_busy && m_left > 0)
            chki("rk_idx", int'(rk_idx), NR + 1 - m_left);
         if (m_ov) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_data: got %h expected no output", out_data);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         nb = m_busy;
         nl = m_left;
         no = m_ov;
         if (m_busy && m_left > 0 && rk_valid) begin
            nl = m_left - 1;
            if (nl == 0) no = 1'b1;
         end
         if (m_ov && out_ready) begin
            no = 1'b0;
            nb = 1'b0;
         end
         if (in_valid && exp_ir) begin
            nb = 1'b1;
            nl = NR + 1;
         end
         m_busy = nb;
         m_left = nl;
         m_ov   = no;
      end
   end

   // ---------------- driver ----------------
   task automatic send(input blk_t pt, input keys_t k, input bit id,
                       input blk_t exp);
      int n;
      n = 0;
      exp_q.push_back(exp);
      pend_keys = k;
      pend_id   = id;
      in_data   = pt;
      in_valid  = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) tmo("accept");
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int c);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      if (!out_valid) tmo("out_valid");
      c = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || busy) tmo("drain");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      keys_t k;
      blk_t  pt;
      blk_t  pa;
      int    c0;
      int    c1;
      int    n;
      bit    id;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // identity datapath, keys = index bytes
      send('0, id_keys(), 1'b1, {16{8'h0b}});
      c0 = acc_cyc;
      wait_ov(c1);
      chki("latency_ident", c1 - c0, NR + 2);
      drain();

      // FIPS-197 known answer
      send(128'h00112233445566778899aabbccddeeff,
           expand(128'h000102030405060708090a0b0c0d0e0f), 1'b0,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      drain();

      // three-cycle key stall at index 5
      rkv_mode = 2;
      send('0, id_keys(), 1'b1, {16{8'h0b}});
      c0 = acc_cyc;
      wait_ov(c1);
      chki("latency_stall", c1 - c0, NR + 5);
      drain();
      rkv_mode = 0;

      // downstream backpressure for four cycles
      ordy_mode = 2;
      pt = rnd_blk();
      k  = rnd_keys();
      send(pt, k, 1'b0, aes_ref(pt, k, 1'b0));
      wait_ov(c1);
      repeat (3) @(negedge clk);
      ordy_mode = 0;
      repeat (2) @(negedge clk);
      chkb("idle_after_ready", busy, 1'b0);
      chkb("no_valid_after_ready", out_valid, 1'b0);
      drain();

      // reset mid-block at key index 6
      pt = rnd_blk();
      send(pt, id_keys(), 1'b1, aes_ref(pt, id_keys(), 1'b1));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rk_idx != 4'd6 && n < 50);
      if (rk_idx != 4'd6) tmo("rk_idx_6");
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chkb("async_rst_out_valid", out_valid, 1'b0);
      chkb("async_rst_in_ready", in_ready, 1'b1);
      chkb("async_rst_busy", busy, 1'b0);
      chkb("async_rst_dp_last", dp_last, 1'b0);
      chki("async_rst_rk_idx", int'(rk_idx), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      pt = rnd_blk();
      k  = rnd_keys();
      send(pt, k, 1'b0, aes_ref(pt, k, 1'b0));
      drain();

      // two blocks offered back to back
      pt = rnd_blk();
      pa = rnd_blk();
      k  = rnd_keys();
      send(pt, k, 1'b0, aes_ref(pt, k, 1'b0));
      c0 = acc_cyc;
      send(pa, k, 1'b0, aes_ref(pa, k, 1'b0));
      c1 = acc_cyc;
      chki("b2b_gap", c1 - c0, B2B ? NR + 2 : NR + 3);
      drain();

      // randomized traffic with key stalls and backpressure
      rkv_mode  = 1;
      ordy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         id = ($urandom_range(0, 1) == 1);
         pt = rnd_blk();
         k  = rnd_keys();
         send(pt, k, id, aes_ref(pt, k, id));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rkv_mode  = 0;
      ordy_mode = 0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES encryption sequencer.
- Owns the 128-bit state register and the round counter.
- Drives one shared combinational round datapath (SubBytes -> Shift_rows -> MixColumns, with MixColumns bypassed on the last round). Requests round keys by index from the key store.
- Sits between the block-level valid/ready input/output streams and the round datapath.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14. Any other value is a elaboration error.
- KIW, 4, width of the round-key index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  controller can accept plaintext.
- in_data  in  [0:127]  plaintext block, byte 0 = bits [0:7].
- rk_idx  out  KIW  round-key index requested.
- rk  in  [0:127]  round key for rk_idx.
- rk_valid  in  1  rk is valid this cycle.
- dp_state  out  [0:127]  current state fed to the round datapath.
- dp_last  out  1  final round; datapath skips MixColumns.
- dp_result  in  [0:127]  combinational datapath result, before AddRoundKey.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  [0:127]  ciphertext; equals the state register.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, state reg=0, round=0.
  - Outputs: out_valid=0, in_ready=1, busy=0, rk_idx=0, dp_last=0.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state<=in_data, rk_idx<=0, go to INIT.
- INIT:
  - If rk_valid: state<=state^rk, round<=1, rk_idx<=1, go to ROUND.
  - Else hold all registers.
- ROUND:
  - If rk_valid: state<=dp_result^rk, round<=round+1, rk_idx<=round+1.
  - If round==NR-1, go to FINAL (dp_last=1 there).
  - Else hold all registers.
- FINAL:
  - dp_last=1.
  - If rk_valid: state<=dp_result^rk, go to DONE.
  - Else hold all registers.
- DONE:
  - out_valid=1, out_data=state.
  - On out_ready: go to IDLE.
  - out_data and out_valid stay stable until the handshake.
- Common rules:
  - rk_idx always equals the key index consumed in the current state.
  - rk_idx is registered and changes only on a state advance.
  - dp_state = state register; dp_last is 1 only in FINAL.
  - in_ready=0 in every state except IDLE (except under the optional feature).
  - Latency with rk_valid held high: accept at cycle T, out_valid at T+NR+2 (12 cycles for NR=10).
  - Each rk_valid=0 cycle adds exactly one cycle; there is no lost or duplicated round.
  - Round counter width is KIW; it never wraps, because it is bounded by NR<=14.
  - in_valid while busy is ignored; the source must hold it, per valid/ready rules.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. The partial result is discarded and never presented.

Optional Feature:
- Macro: AES_BACK2BACK_EN.
- Defined:
  - in_ready = IDLE | (DONE & out_ready).
  - A DONE handshake coinciding with in_valid loads in_data, sets rk_idx<=0 and goes straight to INIT.
  - Sustained throughput: one block per NR+2 cycles.
- Undefined:
  - in_ready only in IDLE.
  - At least one IDLE cycle between blocks (NR+3 cycles per block).

Test Plan:
- Identity datapath, rk_valid=1, rk = all bytes equal to rk_idx, in_data=0 -> out_data = 16 bytes of 0x0B, out_valid at accept+12, dp_last high exactly one cycle.
- Real datapath, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- Identity setup, rk_valid low for 3 cycles while rk_idx=5 -> state and rk_idx=5 held, out_valid at accept+15, same ciphertext 0x0B bytes.
- out_ready low 4 cycles in DONE -> out_valid and out_data stable, in_ready=0, busy=1; IDLE the cycle after out_ready rises.
- rst_n pulsed low at rk_idx=6 -> all outputs at reset values immediately; no out_valid; next block produces the correct ciphertext.
- Two back-to-back blocks with out_ready=1, in_valid=1 -> second accepted in the DONE cycle with AES_BACK2BACK_EN; one IDLE gap without it.
